// File: rtl/simple_i2c_slave.sv
// Simple I2C slave with a register-mapped host side.
// The SCL/SDA inputs are synchronized and edge-detected. One TX byte and one RX byte are buffered.
// The slave never stretches SCL and drives SDA only by pulling the line low.
// The host reads the FSM state on dbg_state so external checkers can follow the protocol.
module simple_i2c_slave (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reg_cfg_we,
    input  logic [31:0] reg_cfg_di,
    output logic [31:0] reg_cfg_do,
    input  logic        reg_sts_we,
    input  logic [31:0] reg_sts_di,
    output logic [31:0] reg_sts_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoeb_o,
    output logic        irq_o,
    output logic [2:0]  dbg_state
);

    // Host side handshake: every reg_*_we / reg_dat_re strobe is sampled for exactly one
    // clk cycle. It takes effect on that rising edge. There is no ready/stall path.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WDATA    = 3'd3,
        WACK     = 3'd4,
        RDATA    = 3'd5,
        RACK     = 3'd6,
        WAIT     = 3'd7
    } state_t;

    state_t     state, state_nx;
    logic [2:0] scl_sync, sda_sync;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [6:0] addr;
    logic       enable, ien;
    logic [7:0] txr, rxr, sr, rx_byte, tx_byte;
    logic [2:0] cnt;
    logic       rx_valid, tx_empty, busy, overrun, underrun, stop_seen, rw;
    logic       ack_ph, nack, sda_low;
    logic       last_bit, addr_match, load_tx;
    logic       unused_bits;

    // Index [1] holds the synchronized level. Index [2] holds the previous level, used for edge detection.
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
    assign stop_det  = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];

    assign rx_byte    = {sr[6:0], sda_sync[1]};
    assign last_bit   = scl_rise && (cnt == 3'd7);
    assign addr_match = (rx_byte[7:1] == addr);
    assign tx_byte    = tx_empty ? 8'hFF : txr;
    // The second falling edge of an ack slot opens a read byte.
    assign load_tx    = enable && !start_det && !stop_det && scl_fall && ack_ph &&
                        ((state == ADDR_ACK && rw) || state == RACK);

    assign reg_cfg_do   = {23'b0, ien, enable, addr};
    assign reg_sts_do   = {24'b0, 1'b0, rw, stop_seen, underrun, overrun, busy, tx_empty, rx_valid};
    assign reg_dat_do   = rx_valid ? {24'b0, rxr} : 32'hFFFF_FFFF;
    assign sda_pad_o    = 1'b0;
    assign sda_padoeb_o = ~sda_low;
    assign irq_o        = ien & (rx_valid | overrun | underrun | stop_seen | (busy & rw & tx_empty));
    assign dbg_state    = state;
    assign unused_bits  = ^{reg_cfg_di[31:9], reg_sts_di[31:6], reg_sts_di[2:0], reg_dat_di[31:8]};

    // The pad inputs pass through a two-flop synchronizer plus one extra stage that holds the previous level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_pad_i};
            sda_sync <= {sda_sync[1:0], sda_pad_i};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic. Disable, STOP and START override the per-state rules, in that order.
    always_comb begin
        state_nx = state;
        if (!enable)        state_nx = IDLE;
        else if (stop_det)  state_nx = IDLE;
        else if (start_det) state_nx = ADDR;
        else begin
            case (state)
                IDLE:     state_nx = IDLE;
                ADDR:     if (last_bit) state_nx = addr_match ? ADDR_ACK : WAIT;
                ADDR_ACK: if (scl_fall && ack_ph) state_nx = rw ? RDATA : WDATA;
                WDATA:    if (last_bit) state_nx = WACK;
                WACK:     if (scl_fall && ack_ph) state_nx = nack ? WAIT : WDATA;
                RDATA:    if (last_bit) state_nx = RACK;
                RACK: begin
                    if (scl_rise && sda_sync[1])  state_nx = WAIT;
                    else if (scl_fall && ack_ph)  state_nx = RDATA;
                end
                WAIT:     state_nx = WAIT;
                default:  state_nx = IDLE;
            endcase
        end
    end

    // Datapath and status registers. Clears come first so that a set in the same cycle wins.
    // A host TX write comes last so that it wins over a same-cycle TX load.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr <= 7'd0; enable <= 1'b0; ien <= 1'b0;
            txr <= 8'd0; rxr <= 8'd0; sr <= 8'd0; cnt <= 3'd0;
            rx_valid <= 1'b0; tx_empty <= 1'b1; busy <= 1'b0; rw <= 1'b0;
            overrun <= 1'b0; underrun <= 1'b0; stop_seen <= 1'b0;
            ack_ph <= 1'b0; nack <= 1'b0; sda_low <= 1'b0;
        end else begin
            if (reg_cfg_we) begin
                addr   <= reg_cfg_di[6:0];
                enable <= reg_cfg_di[7];
                ien    <= reg_cfg_di[8];
            end
            if (reg_dat_re) rx_valid <= 1'b0;
            if (reg_sts_we) begin
                if (reg_sts_di[3]) overrun   <= 1'b0;
                if (reg_sts_di[4]) underrun  <= 1'b0;
                if (reg_sts_di[5]) stop_seen <= 1'b0;
            end

            if (!enable) begin
                sda_low <= 1'b0; busy <= 1'b0; ack_ph <= 1'b0; cnt <= 3'd0;
            end else if (stop_det) begin
                if (busy) stop_seen <= 1'b1;
                busy <= 1'b0; sda_low <= 1'b0; ack_ph <= 1'b0; cnt <= 3'd0;
            end else if (start_det) begin
                sda_low <= 1'b0; ack_ph <= 1'b0; cnt <= 3'd0;
            end else begin
                // The bit counter wraps to 0 on the eighth rising edge, ready for the next byte.
                if (scl_rise && (state == ADDR || state == WDATA || state == RDATA))
                    cnt <= cnt + 3'd1;
                if (scl_rise && (state == ADDR || state == WDATA))
                    sr <= rx_byte;
                if (state == ADDR && last_bit) begin
                    if (addr_match) begin
                        busy <= 1'b1;
                        rw   <= rx_byte[0];
                    end else begin
                        busy <= 1'b0;
                    end
                end
                if (state == WDATA && last_bit) begin
                    if (!rx_valid) begin
                        rxr <= rx_byte; rx_valid <= 1'b1; nack <= 1'b0;
                    end else begin
                        overrun <= 1'b1; nack <= 1'b1;
                    end
                end
                if (state == RDATA && scl_fall) begin
                    sr      <= {sr[6:0], 1'b1};
                    sda_low <= ~sr[6];
                end
                if ((state == ADDR_ACK || state == WACK || state == RACK) && scl_fall) begin
                    if (!ack_ph) begin
                        // First falling edge: drive our ACK, or release SDA for the master's ACK.
                        ack_ph  <= 1'b1;
                        sda_low <= (state == ADDR_ACK) || (state == WACK && !nack);
                    end else begin
                        ack_ph  <= 1'b0;
                        sda_low <= 1'b0;
                        if (load_tx) begin
                            sr      <= tx_byte;
                            sda_low <= ~tx_byte[7];
                            if (tx_empty) underrun <= 1'b1;
                            else          tx_empty <= 1'b1;
                        end
                    end
                end
                if (state == RACK && scl_rise && sda_sync[1])
                    ack_ph <= 1'b0;
            end

            if (reg_dat_we) begin
                txr      <= reg_dat_di[7:0];
                tx_empty <= 1'b0;
            end
        end
    end

endmodule
